bit_serial_adder: RTL and testbench

- LSB-first bit-serial adder for two WIDTH-bit unsigned operands; the dataflow-level sequential consumer of the half-adder cell.
- Per cycle, one bit pair passes through a full-adder slice built from two half adders. A carry flip-flop closes the loop between cycles.
- Operands are accepted with a valid/ready handshake. The WIDTH-bit sum and carry-out are presented with a valid/ready handshake.
- Serves as the multi-cycle arithmetic stage in the team's adder exercises.

---
 rtl/bit_serial_adder_pkg.sv | 9 +
 rtl/bit_serial_adder_fa_slice.sv | 13 +
 rtl/bit_serial_adder.sv | 71 +++++++
 tb/tb_bit_serial_adder.sv | 174 +++++++++++++++++
 4 files changed

// File: rtl/bit_serial_adder_pkg.sv
// bit_serial_adder_pkg: shared FSM state encoding and default width for the serial adder
package bit_serial_adder_pkg;
   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      SHIFT = 2'd1,
      DONE  = 2'd2
   } state_t;
   localparam int DEFAULT_WIDTH = 8;
endpackage

// File: rtl/bit_serial_adder_fa_slice.sv
// fa_slice: combinational full adder composed of two half-adder stages
module fa_slice (
   input  logic a,
   input  logic b,
   input  logic c,
   output logic s,
   output logic c_out
);
   logic p;
   assign p     = a ^ b;
   assign s     = p ^ c;
   assign c_out = (a & b) | (c & p);
endmodule

// File: rtl/bit_serial_adder.sv
// bit_serial_adder: LSB-first serial adder with valid/ready handshakes (SERIAL_ADD_CIN_EN adds a carry-in port)
module bit_serial_adder
   import bit_serial_adder_pkg::*;
#(
   parameter int WIDTH = DEFAULT_WIDTH
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] a_in,
   input  logic [WIDTH-1:0] b_in,
`ifdef SERIAL_ADD_CIN_EN
   input  logic             cin,
`endif
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] sum_out,
   output logic             cout_out,
   output logic             busy
);
   localparam int CW = $clog2(WIDTH);
   state_t           state, next;
   logic [WIDTH-1:0] a_sr, b_sr, sum_sr;
   logic [CW-1:0]    cnt;
   logic             carry, s, c, load, last, cin_v;
`ifdef SERIAL_ADD_CIN_EN
   assign cin_v = cin;
`else
   assign cin_v = 1'b0;
`endif
   fa_slice u_fa (.a(a_sr[0]), .b(b_sr[0]), .c(carry), .s(s), .c_out(c));
   assign load = in_valid && in_ready;
   assign last = cnt == CW'(WIDTH - 1);
   // state register
   always_ff @(posedge clk or negedge rst_n)
      if (!rst_n) state <= IDLE;
      else state <= next;
   // next-state and handshake outputs
   always_comb begin
      in_ready  = state == IDLE;
      busy      = state == SHIFT;
      out_valid = state == DONE;
      sum_out   = state == DONE ? sum_sr : '0;
      cout_out  = state == DONE ? carry : 1'b0;
      next      = state == IDLE  ? (in_valid ? SHIFT : IDLE) :
                  state == SHIFT ? (last ? DONE : SHIFT) :
                  state == DONE  ? (out_ready ? IDLE : DONE) : IDLE;
   end
   // operand load and one bit per cycle through the slice while shifting
   always_ff @(posedge clk or negedge rst_n)
      if (!rst_n) begin
         a_sr   <= '0;
         b_sr   <= '0;
         sum_sr <= '0;
         carry  <= 1'b0;
         cnt    <= '0;
      end else if (load) begin
         a_sr   <= a_in;
         b_sr   <= b_in;
         sum_sr <= '0;
         carry  <= cin_v;
         cnt    <= '0;
      end else if (state == SHIFT) begin
         a_sr   <= {1'b0, a_sr[WIDTH-1:1]};
         b_sr   <= {1'b0, b_sr[WIDTH-1:1]};
         sum_sr <= {s, sum_sr[WIDTH-1:1]};
         carry  <= c;
         cnt    <= cnt + CW'(1);
      end
endmodule

// File: tb/tb_bit_serial_adder.sv
// tb_bit_serial_adder: directed table-driven checks of 8-bit and 4-bit serial adders
module tb_bit_serial_adder;
   logic       clk = 1'b0, rst_n = 1'b0;
   logic       iv8 = 0, ir8, ov8, or8 = 0, co8, bz8;
   logic [7:0] a8 = 0, b8 = 0, s8;
   logic       iv4 = 0, ir4, ov4, or4 = 0, co4, bz4;
   logic [3:0] a4 = 0, b4 = 0, s4;
`ifdef SERIAL_ADD_CIN_EN
   logic       cin8 = 0, cin4 = 0;
`endif
   int n_chk = 0, n_fail = 0;

   always #5 clk = ~clk;

   bit_serial_adder #(.WIDTH(8)) u8 (
      .clk(clk), .rst_n(rst_n), .in_valid(iv8), .in_ready(ir8), .a_in(a8), .b_in(b8),
`ifdef SERIAL_ADD_CIN_EN
      .cin(cin8),
`endif
      .out_valid(ov8), .out_ready(or8), .sum_out(s8), .cout_out(co8), .busy(bz8));

   bit_serial_adder #(.WIDTH(4)) u4 (
      .clk(clk), .rst_n(rst_n), .in_valid(iv4), .in_ready(ir4), .a_in(a4), .b_in(b4),
`ifdef SERIAL_ADD_CIN_EN
      .cin(cin4),
`endif
      .out_valid(ov4), .out_ready(or4), .sum_out(s4), .cout_out(co4), .busy(bz4));

   typedef struct {
      bit         w4;
      logic [7:0] a, b, sum;
      logic       cout;
   } vec_t;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   // one full operation: accept, count edges to out_valid, capture result, complete transfer
   task automatic run(input bit w4, input logic [7:0] a, input logic [7:0] b, input logic ci,
                      input bit hold, output logic [7:0] s, output logic c, output int lat);
      @(negedge clk);
      if (w4) begin
         a4 = a[3:0]; b4 = b[3:0]; iv4 = 1; or4 = hold;
         chk("in_ready_idle4", 32'(ir4), 1);
      end else begin
         a8 = a; b8 = b; iv8 = 1; or8 = hold;
         chk("in_ready_idle8", 32'(ir8), 1);
      end
`ifdef SERIAL_ADD_CIN_EN
      cin4 = ci; cin8 = ci;
`else
      if (ci) ;
`endif
      @(posedge clk);
      lat = 0;
      while (lat < 40) begin
         @(negedge clk);
         if (w4) begin iv4 = 1; a4 = ~a4; b4 = ~b4; end
         else begin iv8 = 1; a8 = ~a8; b8 = ~b8; end
         if (lat == 0) begin
            chk("busy_shift", 32'(w4 ? bz4 : bz8), 1);
            chk("in_ready_shift", 32'(w4 ? ir4 : ir8), 0);
         end
         if (w4 ? ov4 : ov8) break;
         @(posedge clk);
         lat++;
      end
      iv4 = 0; iv8 = 0;
      s = w4 ? {4'b0, s4} : s8;
      c = w4 ? co4 : co8;
      if (w4) or4 = 1; else or8 = 1;
      @(posedge clk);
      @(negedge clk);
      chk("out_valid_drop", 32'(w4 ? ov4 : ov8), 0);
      chk("in_ready_back", 32'(w4 ? ir4 : ir8), 1);
      if (hold) begin
         @(negedge clk);
         chk("single_xfer", 32'(w4 ? ov4 : ov8), 0);
      end
      or4 = 0; or8 = 0;
   endtask

   initial begin
      vec_t       v[9];
      logic [7:0] s, hs;
      logic       c, hc;
      int         lat;
      v[0] = '{1, 8'h0F, 8'h01, 8'h00, 1};
      v[1] = '{0, 8'd100, 8'd27, 8'd127, 0};
      v[2] = '{0, 8'hFF, 8'hFF, 8'hFE, 1};
      v[3] = '{0, 8'h00, 8'h00, 8'h00, 0};
      v[4] = '{1, 8'h00, 8'h00, 8'h00, 0};
      v[5] = '{1, 8'h0F, 8'h0F, 8'h0E, 1};
      v[6] = '{0, 8'h80, 8'h80, 8'h00, 1};
      v[7] = '{0, 8'h55, 8'hAA, 8'hFF, 0};
      v[8] = '{1, 8'h09, 8'h06, 8'h0F, 0};

      repeat (3) @(negedge clk);
      chk("rst_in_ready", 32'(ir8), 1);
      chk("rst_out_valid", 32'(ov8), 0);
      chk("rst_busy", 32'(bz8), 0);
      chk("rst_sum", 32'(s8), 0);
      chk("rst_cout", 32'(co8), 0);
      chk("rst_in_ready4", 32'(ir4), 1);
      rst_n = 1;

      for (int i = 0; i < 9; i++) begin
         run(v[i].w4, v[i].a, v[i].b, 1'b0, i[0], s, c, lat);
         chk($sformatf("sum_%0d", i), 32'(s), 32'(v[i].sum));
         chk($sformatf("cout_%0d", i), 32'(c), 32'(v[i].cout));
         chk($sformatf("lat_%0d", i), 32'(lat), v[i].w4 ? 4 : 8);
      end

      // backpressure: result held 10 cycles while out_ready stays low
      @(negedge clk);
      a8 = 8'd100; b8 = 8'd27; iv8 = 1;
      @(negedge clk);
      iv8 = 0;
      for (int i = 0; i < 20 && !ov8; i++) @(negedge clk);
      chk("bp_valid", 32'(ov8), 1);
      for (int i = 0; i < 10; i++) begin
         @(negedge clk);
         chk("bp_sum", 32'(s8), 127);
         chk("bp_ovalid", 32'(ov8), 1);
         chk("bp_in_ready", 32'(ir8), 0);
      end
      or8 = 1;
      @(negedge clk);
      or8 = 0;
      chk("bp_xfer_ov", 32'(ov8), 0);
      chk("bp_xfer_ir", 32'(ir8), 1);

      // asynchronous abort during the third shift cycle
      @(negedge clk);
      a8 = 8'hFF; b8 = 8'h01; iv8 = 1;
      @(posedge clk);
      #1 iv8 = 0;
      repeat (2) @(posedge clk);
      #1 rst_n = 0;
      #1;
      chk("abort_busy", 32'(bz8), 0);
      chk("abort_in_ready", 32'(ir8), 1);
      chk("abort_ov", 32'(ov8), 0);
      chk("abort_sum", 32'(s8), 0);
      @(negedge clk);
      rst_n = 1;
      repeat (12) begin
         @(negedge clk);
         chk("abort_no_emit", 32'(ov8), 0);
      end
      run(0, 8'd3, 8'd4, 1'b0, 0, s, c, lat);
      chk("post_abort_sum", 32'(s), 7);
      chk("post_abort_cout", 32'(c), 0);

      // carry-in: 7+8+1 wraps to zero with carry when the port exists
      run(1, 8'h07, 8'h08, 1'b1, 0, s, c, lat);
`ifdef SERIAL_ADD_CIN_EN
      hs = 8'h00; hc = 1;
`else
      hs = 8'h0F; hc = 0;
`endif
      chk("cin_sum", 32'(s), 32'(hs));
      chk("cin_cout", 32'(c), 32'(hc));
      chk("cin_lat", 32'(lat), 4);

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end
endmodule
